led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
//  Shares the board LED bank (driven from PS7 FCLK-derived clk) between NREQ
//  requesters. Round-robin arbitration; bounded hold with fairness preemption.
//  With no owner, the bank shows a free-running rotating heartbeat pattern.
//  Sits between the LED pins and any logic wanting to display status.
// PARAMETERS
//  NREQ      4         number of requesters (>=2)
//  LED_W     6         LED bank width
//  PERIOD    50000000  heartbeat rotate interval, clk cycles (>=2)
//  MAX_HOLD  5000000   grant cycles before owner may be preempted (>=2)
// PORTS
//  clk      in   1            FCLK-derived clock; all state on posedge
//  rst_n    in   1            async active-low reset
//  req      in   NREQ         level request, bit i = requester i
//  req_led  in   NREQ*LED_W   requester i pattern at [i*LED_W +: LED_W]
//  gnt      out  NREQ         registered one-hot grant, or all zero
//  busy     out  1            registered; 1 when state==GRANT
//  led      out  LED_W        registered LED bank drive
// BEHAVIOUR
//  Reset (async, immediate): led=000001 (LSB set), gnt=0, busy=0, state=IDLE,
//   hb=000001, hb_ctr=0, hold_ctr=0, last=NREQ-1 (first winner is req 0).
//  Heartbeat: hb_ctr counts 0..PERIOD-1 in every state; at PERIOD-1 wraps to 0
//   and hb rotates left ({hb[LED_W-2:0],hb[LED_W-1]}); MSB wraps to LSB.
//  Arbitration: winner = first set req bit scanning last+1, last+2, ... mod
//   NREQ. Combinational from current req; result registered.
//  States:
//   IDLE: led<=hb (next value if hb rotating this edge). If |req: on the same
//    edge gnt<=onehot(winner), last<=winner, led<=req_led[winner],
//    hold_ctr<=0, go GRANT. Latency req->gnt/led = 1 clk.
//   GRANT: led<=req_led[owner] each edge (1-clk lag from req_led).
//    hold_ctr increments, saturates at MAX_HOLD-1.
//    -> RELEASE if req[owner]==0, or if hold_ctr==MAX_HOLD-1 and
//       (req & ~gnt)!=0 (preempt). Both true: RELEASE, same result.
//    Owner alone past MAX_HOLD: stays in GRANT indefinitely.
//   RELEASE (exactly 1 clk): gnt=0, busy=0, led holds last owner value.
//    Next edge: if |req -> arbitrate as IDLE (winner searched after last, so
//    a preempted owner still requesting goes to the back), go GRANT;
//    else led<=hb, go IDLE.
//  gnt falls on the edge entering RELEASE; owner may drop req any time.
//  Invariants: gnt is zero or one-hot; busy == |gnt; gnt never rises for
//   a requester whose req was 0 at the sampling edge.
//  Reset mid-GRANT: all outputs to reset values at once; heartbeat restarts;
//   rr pointer restarts at req 0.
//  No X propagation: req_led slices of non-owners are ignored.
// TESTING (NREQ=4, LED_W=6, PERIOD=4, MAX_HOLD=8)
//  1 req=0 after reset -> led 000001, 000010 after 4 clks, ..., 100000 then
//    000001 after 24 clks; gnt=0, busy=0 throughout.
//  2 req=0001, req_led0=101010 -> next clk gnt=0001, busy=1, led=101010;
//    change req_led0=010101 -> led follows 1 clk later; drop req -> next
//    clk gnt=0 (RELEASE), following clk led=current hb, state IDLE.
//  3 req=1111 held -> grants 0001,0010,0100,1000,0001..., each 8 clks of gnt
//    then 1 clk gnt=0; led shows each owner's pattern.
//  4 req=0001 only, held 30 clks -> gnt=0001 continuous, no preemption; then
//    assert req[2] at clk 30 -> gnt drops next edge, 0100 one clk later.
//  5 req=0110 with last=1 -> winner req 2, not req 1; req[0] and req[1] drop
//    on preempt edge simultaneously -> next owner per scan, no glitch grant.
//  6 rst_n low mid-GRANT (async, between edges) -> led=000001, gnt=0, busy=0
//    immediately; release with req=1111 -> first grant 0001.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank with bounded hold and fairness
// preemption; shows a rotating heartbeat whenever nobody owns the bank.
module led_bank_arbiter #(
   parameter int NREQ     = 4,
   parameter int LED_W    = 6,
   parameter int PERIOD   = 50000000,
   parameter int MAX_HOLD = 5000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*LED_W-1:0]   req_led,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic [LED_W-1:0]        led,
   output logic [1:0]              dbg_state_o
);

   localparam int IDX_W  = $clog2(NREQ);
   localparam int HB_W   = $clog2(PERIOD);
   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(PERIOD - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                busy_q, busy_d;
   logic [LED_W-1:0]    led_q, led_d;
   logic [LED_W-1:0]    hb_q, hb_d;
   logic [HB_W-1:0]     hb_ctr_q, hb_ctr_d;
   logic [HOLD_W-1:0]   hold_ctr_q, hold_ctr_d;
   logic [IDX_W-1:0]    last_q, last_d;

   logic                hb_wrap;
   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic [NREQ-1:0]     win_onehot;
   logic [LED_W-1:0]    win_led;
   logic [LED_W-1:0]    owner_led;
   logic                preempt;

   // Scan downwards so the lowest offset after last_q is the final assignment.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last_q) + k) % NREQ]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((int'(last_q) + k) % NREQ);
         end
      end
      win_onehot[win_idx] = 1'b1;
   end

   assign win_led   = req_led[int'(win_idx) * LED_W +: LED_W];
   assign owner_led = req_led[int'(last_q) * LED_W +: LED_W];
   assign preempt   = (hold_ctr_q == HOLD_LAST) && ((req & ~gnt_q) != '0);
   assign hb_wrap   = (hb_ctr_q == HB_LAST);

   always_comb begin
      hb_ctr_d   = hb_wrap ? '0 : hb_ctr_q + 1'b1;
      hb_d       = hb_wrap ? {hb_q[LED_W-2:0], hb_q[LED_W-1]} : hb_q;
      state_d    = state_q;
      gnt_d      = gnt_q;
      led_d      = led_q;
      last_d     = last_q;
      hold_ctr_d = hold_ctr_q;
      case (state_q)
         // RELEASE re-arbitrates exactly like IDLE; last_q puts the old owner last.
         ST_IDLE, ST_RELEASE: begin
            if (win_found) begin
               state_d    = ST_GRANT;
               gnt_d      = win_onehot;
               last_d     = win_idx;
               led_d      = win_led;
               hold_ctr_d = '0;
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               led_d   = hb_d;
            end
         end
         ST_GRANT: begin
            if (!req[last_q] || preempt) begin
               state_d = ST_RELEASE;
               gnt_d   = '0;
            end else begin
               led_d = owner_led;
               if (hold_ctr_q != HOLD_LAST) hold_ctr_d = hold_ctr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d == ST_GRANT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
         led_q      <= LED_W'(1);
         hb_q       <= LED_W'(1);
         hb_ctr_q   <= '0;
         hold_ctr_q <= '0;
         last_q     <= LAST_RST;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         busy_q     <= busy_d;
         led_q      <= led_d;
         hb_q       <= hb_d;
         hb_ctr_q   <= hb_ctr_d;
         hold_ctr_q <= hold_ctr_d;
         last_q     <= last_d;
      end
   end

   assign gnt         = gnt_q;
   assign busy        = busy_q;
   assign led         = led_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with NREQ=4, LED_W=6, PERIOD=4, MAX_HOLD=8.
module tb_led_bank_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [23:0] req_led;
   logic [3:0]  gnt;
   logic        busy;
   logic [5:0]  led;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  req;
      logic [23:0] rled;
      logic [3:0]  gnt;
      logic        busy;
      logic [5:0]  led;
   } vec_t;

   vec_t vec [8];
   logic [5:0] slice_led [4];
   logic [23:0] own_led;

   led_bank_arbiter #(
      .NREQ(4), .LED_W(6), .PERIOD(4), .MAX_HOLD(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_led(req_led),
      .gnt(gnt), .busy(busy), .led(led), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] eg, input logic eb,
                             input logic [5:0] el);
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".busy"}, 32'(busy), 32'(eb));
      chk({tag, ".led"}, 32'(led), 32'(el));
   endtask

   // Reset pulse placed between clock edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = '0;
      req_led = '0;
      slice_led[0] = 6'h11;
      slice_led[1] = 6'h22;
      slice_led[2] = 6'h33;
      slice_led[3] = 6'h04;
      own_led = {slice_led[3], slice_led[2], slice_led[1], slice_led[0]};

      vec[0] = '{4'b0001, {6'h3f, 6'h0c, 6'h33, 6'h2a}, 4'b0001, 1'b1, 6'b101010};
      vec[1] = '{4'b0001, {6'h3f, 6'h0c, 6'h33, 6'h2a}, 4'b0001, 1'b1, 6'b101010};
      vec[2] = '{4'b0001, {6'h3f, 6'h0c, 6'h33, 6'h15}, 4'b0001, 1'b1, 6'b010101};
      vec[3] = '{4'b0001, {6'h01, 6'h2d, 6'h3c, 6'h15}, 4'b0001, 1'b1, 6'b010101};
      vec[4] = '{4'b0000, {6'h2e, 6'h07, 6'h19, 6'h15}, 4'b0000, 1'b0, 6'b010101};
      vec[5] = '{4'b0000, 24'habcdef,                   4'b0000, 1'b0, 6'b000010};
      vec[6] = '{4'b0000, 24'h123456,                   4'b0000, 1'b0, 6'b000010};
      vec[7] = '{4'b0000, 24'hfedcba,                   4'b0000, 1'b0, 6'b000100};

      #11;
      expect_out("reset", 4'b0000, 1'b0, 6'b000001);
      rst_n = 1'b1;

      // Heartbeat with no requests: one rotation every 4 clocks, full cycle in 24.
      for (int n = 1; n <= 24; n++) begin
         tick();
         expect_out($sformatf("hb[%0d]", n), 4'b0000, 1'b0, 6'(6'b000001 << ((n / 4) % 6)));
      end

      // Single owner, pattern tracking, drop and return to heartbeat.
      for (int i = 0; i < 8; i++) begin
         req     = vec[i].req;
         req_led = vec[i].rled;
         tick();
         expect_out($sformatf("single[%0d]", i), vec[i].gnt, vec[i].busy, vec[i].led);
      end

      // All four requesting: 8 clocks of grant, 1 clock of release, rotating owner.
      tick();
      do_reset();
      req     = 4'b1111;
      req_led = own_led;
      tick();
      for (int g = 0; g < 6; g++) begin
         for (int c = 0; c < 8; c++) begin
            expect_out($sformatf("rr[%0d.%0d]", g, c), 4'(4'b0001 << (g % 4)), 1'b1,
                       slice_led[g % 4]);
            tick();
         end
         expect_out($sformatf("rr_rel[%0d]", g), 4'b0000, 1'b0, slice_led[g % 4]);
         tick();
      end

      // Lone owner past MAX_HOLD keeps the bank until someone else asks.
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 30; c++) begin
         tick();
         expect_out($sformatf("lone[%0d]", c), 4'b0001, 1'b1, slice_led[0]);
      end
      req = 4'b0101;
      tick();
      expect_out("lone_pre", 4'b0000, 1'b0, slice_led[0]);
      tick();
      expect_out("lone_next", 4'b0100, 1'b1, slice_led[2]);

      // Pointer after req 1: req 2 wins over req 1; losers drop during release.
      do_reset();
      req = 4'b0010;
      tick();
      expect_out("p_g1", 4'b0010, 1'b1, slice_led[1]);
      req = 4'b0000;
      tick();
      chk("p_rel.gnt", 32'(gnt), 32'd0);
      tick();
      chk("p_idle.gnt", 32'(gnt), 32'd0);
      req = 4'b0110;
      tick();
      expect_out("p_win2", 4'b0100, 1'b1, slice_led[2]);
      req = 4'b0111;
      for (int c = 1; c < 8; c++) begin
         tick();
         chk($sformatf("p_hold[%0d]", c), 32'(gnt), 32'b0100);
      end
      tick();
      expect_out("p_pre", 4'b0000, 1'b0, slice_led[2]);
      req = 4'b0100;
      tick();
      expect_out("p_regrant", 4'b0100, 1'b1, slice_led[2]);

      // Asynchronous reset while granted.
      #3;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 4'b0000, 1'b0, 6'b000001);
      req = 4'b1111;
      #1;
      rst_n = 1'b1;
      tick();
      expect_out("rst_first", 4'b0001, 1'b1, slice_led[0]);

      // Heartbeat phase restarts from reset.
      #3;
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      rst_n = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         expect_out($sformatf("hb_restart[%0d]", n), 4'b0000, 1'b0,
                    (n == 4) ? 6'b000010 : 6'b000001);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
